// File: rtl/ram_ctrl.sv
// Single-port word RAM behind a request/acknowledge controller.
// A request is latched in IDLE, optionally held for WAIT_STATES cycles,
// performed in ACCESS and acknowledged with a one-cycle done pulse.
module ram_ctrl #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 9,
  parameter int    DEPTH       = 512,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    is_write;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // Address decode of the latched request.
  always_comb begin
    in_range = (32'(addr_q) < 32'(DEPTH));
    idx      = addr_q[IDX_W-1:0];
  end

  // Controller FSM with registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      is_write <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (read || write) begin
            addr_q   <= address;
            data_q   <= data_in;
            is_write <= write;
            busy     <= 1'b1;
            addr_err <= 1'b0;
            wait_cnt <= 4'(WAIT_STATES);
            state    <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= '0;
            state    <= ST_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (!is_write) begin
            data_out <= in_range ? mem[idx] : '0;
          end
          addr_err <= !in_range;
          done     <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array write port; state is forced to IDLE by reset, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && is_write && in_range) begin
      mem[idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Testbench for ram_ctrl: constant vector table, hand-written corner
// sequences and randomized traffic checked against an array-based model.
module tb_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 500;
    localparam int WS    = 1;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] data_out;
    logic          busy, done, addr_err;

    logic          rd0 = 1'b0, wr0 = 1'b0, rd15 = 1'b0, wr15 = 1'b0;
    logic [DW-1:0] dout0, dout15;
    logic          busy0, done0, err0, busy15, done15, err15;

    int checks = 0;
    int errors = 0;

    // reference model: plain storage plus the observable output registers
    logic [DW-1:0] m_mem [0:DEPTH-1];
    logic [DW-1:0] m_dout;
    logic          m_err;

    always #5 clk = ~clk;

    ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .clr(clr), .address(address), .data_in(data_in),
        .read(read), .write(write), .data_out(data_out),
        .busy(busy), .done(done), .addr_err(addr_err));

    ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(512), .WAIT_STATES(0)) dut0 (
        .clk(clk), .clr(clr), .address(address), .data_in(data_in),
        .read(rd0), .write(wr0), .data_out(dout0),
        .busy(busy0), .done(done0), .addr_err(err0));

    ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(512), .WAIT_STATES(15)) dut15 (
        .clk(clk), .clr(clr), .address(address), .data_in(data_in),
        .read(rd15), .write(wr15), .data_out(dout15),
        .busy(busy15), .done(done15), .addr_err(err15));

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_do;
        bit            exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model of one completed request, from the behavioural rules only.
    task automatic model_apply(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        ok = (int'(a) < DEPTH);
        m_err = !ok;
        if (wr) begin
            if (ok) m_mem[a] = d;
        end else if (rd) begin
            m_dout = ok ? m_mem[a] : '0;
        end
    endtask

    // Issue one request on the main DUT and check handshake, latency and results.
    // done registers at edge N+WS+1, so it is first seen high WS+1 samples after acceptance.
    task automatic run_req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_do, input bit exp_err, input string name);
        int cyc;
        @(negedge clk);
        read = rd; write = wr; address = a; data_in = d;
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        address = AW'($urandom); data_in = $urandom;
        chk({name, "_busy_on"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, WS + 1);
        chk({name, "_data_out"}, data_out, exp_do);
        chk({name, "_addr_err"}, 32'(addr_err), 32'(exp_err));
        chk({name, "_busy_done"}, 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    // Latency and data on the WAIT_STATES=0 / 15 instances.
    task automatic aux_req(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] exp_do, input int exp_lat, input string name);
        int cyc;
        @(negedge clk);
        address = a; data_in = d;
        if (k == 0) begin rd0 = !wr; wr0 = wr; end
        else        begin rd15 = !wr; wr15 = wr; end
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0; rd15 = 1'b0; wr15 = 1'b0;
        cyc = 0;
        while (!((k == 0) ? done0 : done15) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_data_out"}, (k == 0) ? dout0 : dout15, exp_do);
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        int dcount;
        vecs[0] = '{1'b0, 1'b1, 9'd95,  32'h0000_000D, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 9'd95,  32'h0,         32'h0000_000D, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 9'd38,  32'h0000_0005, 32'h0000_000D, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 9'd38,  32'h0,         32'h0000_0005, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 9'd510, 32'h0,         32'h0000_0000, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 9'd499, 32'h0000_00AA, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 9'd499, 32'h0,         32'h0000_00AA, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 9'd500, 32'h0000_00BB, 32'h0000_00AA, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 9'd500, 32'h0,         32'h0000_0000, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 9'd95,  32'h0,         32'h0000_000D, 1'b0};
        m_dout = '0;
        m_err  = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // reset state
        #12;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        @(posedge clk); #3;
        clr = 1'b1;

        // vector table: first request is accepted at the first edge after reset release
        for (int i = 0; i < 10; i++) begin
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                    vecs[i].exp_do, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // second request while busy is ignored: one done pulse, first write's data kept
        @(negedge clk);
        write = 1'b1; address = 9'd60; data_in = 32'h11;
        @(posedge clk); #1;
        read = 1'b1; write = 1'b1; data_in = 32'h22;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin read = 1'b0; write = 1'b0; end
            if (done) dcount++;
        end
        chk("busy_ignore_pulses", dcount, 1);
        model_apply(1'b0, 1'b1, 9'd60, 32'h11);
        model_apply(1'b1, 1'b0, 9'd60, 32'h0);
        run_req(1'b1, 1'b0, 9'd60, 32'h0, 32'h11, 1'b0, "busy_ignore_read");

        // reset during WAIT of a write: outputs cleared, memory keeps old value
        model_apply(1'b0, 1'b1, 9'd51, 32'h3);
        run_req(1'b0, 1'b1, 9'd51, 32'h3, m_dout, 1'b0, "abort_pre_write");
        @(negedge clk);
        write = 1'b1; address = 9'd51; data_in = 32'h7;
        @(posedge clk); #1;
        write = 1'b0;
        #1 clr = 1'b0;
        #1;
        chk("abort_data_out", data_out, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_addr_err", 32'(addr_err), 32'd0);
        m_dout = '0; m_err = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        clr = 1'b1;
        model_apply(1'b1, 1'b0, 9'd51, 32'h0);
        run_req(1'b1, 1'b0, 9'd51, 32'h0, 32'h3, 1'b0, "abort_read_back");

        // randomized traffic around the DEPTH boundary against the model
        for (int a = 470; a < DEPTH; a++) begin
            logic [DW-1:0] d;
            d = $urandom;
            model_apply(1'b0, 1'b1, AW'(a), d);
            run_req(1'b0, 1'b1, AW'(a), d, m_dout, m_err, "rnd_init");
        end
        for (int n = 0; n < 120; n++) begin
            int op;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            op = $urandom_range(0, 2);
            a  = AW'($urandom_range(470, 511));
            d  = $urandom;
            model_apply(op != 1, op != 0, a, d);
            run_req(op != 1, op != 0, a, d, m_dout, m_err, $sformatf("rnd%0d", n));
        end

        // zero and maximum wait states
        aux_req(0, 1'b1, 9'd7, 32'h77, 32'h0, 1, "ws0_write");
        aux_req(0, 1'b0, 9'd7, 32'h0, 32'h77, 1, "ws0_read");
        aux_req(1, 1'b1, 9'd7, 32'h99, 32'h0, 16, "ws15_write");
        aux_req(1, 1'b0, 9'd7, 32'h0, 32'h99, 16, "ws15_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute time limit so the bench always ends
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
